// File: rtl/router_pkg.sv
// router_pkg: shared header layout constants and controller state encoding.
package router_pkg;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_W = 2;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_LEN_W = 6;
  localparam int N_PORTS = 3;
  typedef enum logic [2:0] {IDLE, HDR_WAIT, PAYLOAD, CHECK, DROP_HDR} state_e;
endpackage

// File: rtl/router_pkt_track.sv
// router_pkt_track: payload length down-counter and running XOR parity accumulator.
module router_pkt_track
  import router_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [HDR_LEN_W-1:0] len,
  input  logic [DATA_W-1:0]    din,
  output logic                 zero,
  output logic                 match
);
  logic [HDR_LEN_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  always_comb begin
    rem_d = load ? len : (step && rem_q != '0) ? rem_q - HDR_LEN_W'(1) : rem_q;
    acc_d = load ? din : step ? acc_q ^ din : acc_q;
    zero  = rem_q == '0;
    match = (acc_q ^ din) == '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      acc_q <= '0;
    end else begin
      rem_q <= rem_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: parses router packet headers, steers bytes to one of N_PORTS FIFOs,
// applies backpressure and flags parity errors and rejected headers.
module router_pkt_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_PORTS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pkt_valid,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [N_PORTS-1:0] fifo_full,
  output logic               busy,
  output logic [N_PORTS-1:0] wr_en,
  output logic [DATA_W-1:0]  wr_data,
  output logic               pkt_done,
  output logic               parity_err,
  output logic               drop
);
  import router_pkg::*;
  localparam logic [N_PORTS-1:0] ONE = 1;
  state_e                  state_q, state_d;
  logic [HDR_ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]       hdr_q, hdr_d, wr_data_q, wr_data_d;
  logic [N_PORTS-1:0]      wr_en_q, wr_en_d;
  logic                    err_q, err_d;
  logic [2**HDR_ADDR_W-1:0] full_x;
  logic [HDR_ADDR_W-1:0]   addr;
  logic [HDR_LEN_W-1:0]    len;
  logic                    accept, load, step, zero, match;
  assign addr = data_in[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign len  = data_in[HDR_LEN_LSB +: HDR_LEN_W];
  assign wr_en = wr_en_q;
  assign wr_data = wr_data_q;
  // Full flags padded so unused address codes index safely as not-full.
  always_comb begin
    full_x = '0;
    full_x[N_PORTS-1:0] = fifo_full;
    busy = (state_q inside {HDR_WAIT, CHECK, DROP_HDR}) || (state_q == PAYLOAD && full_x[dest_q]);
    accept = pkt_valid && !busy;
    load = state_q == IDLE && accept;
    step = state_q == PAYLOAD && accept;
    pkt_done = state_q == CHECK || state_q == DROP_HDR;
    drop = state_q == DROP_HDR;
    parity_err = state_q == CHECK && err_q;
  end
  always_comb begin
    state_d = state_q;
    dest_d = dest_q;
    hdr_d = hdr_q;
    err_d = err_q;
    wr_en_d = '0;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (accept) begin
        dest_d = addr;
        hdr_d = data_in;
        if (int'(addr) >= N_PORTS || len == '0) state_d = DROP_HDR;
        else if (full_x[addr]) state_d = HDR_WAIT;
        else begin
          wr_en_d = ONE << addr;
          wr_data_d = data_in;
          state_d = PAYLOAD;
        end
      end
      HDR_WAIT: if (!full_x[dest_q]) begin
        wr_en_d = ONE << dest_q;
        wr_data_d = hdr_q;
        state_d = PAYLOAD;
      end
      PAYLOAD: if (accept) begin
        wr_en_d = ONE << dest_q;
        wr_data_d = data_in;
        if (zero) begin
          err_d = !match;
          state_d = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dest_q <= '0;
      hdr_q <= '0;
      err_q <= 1'b0;
      wr_en_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      hdr_q <= hdr_d;
      err_q <= err_d;
      wr_en_q <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end
  router_pkt_track #(.DATA_W(DATA_W)) u_track (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .len  (len),
    .din  (data_in),
    .zero (zero),
    .match(match)
  );
endmodule
